retire_queue: RTL and testbench

- Downstream consumer of the two-lane writeback stage.
- Holds completed instructions in a table indexed by scoreboard id (sid).
- Retires them in program order, up to 2 per cycle: drives the two register-file write ports and the scoreboard release.
- Turns a writeback redirect into an ordered drain, then a single flush pulse.

---
 rtl/retire_queue_pkg.sv | 28 ++
 rtl/retire_queue_table.sv | 113 +++++++++++
 rtl/retire_queue.sv | 234 +++++++++++++++++++++++
 tb/tb_retire_queue.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_queue_pkg.sv
// Shared types for the in-order retire queue: sid sizing, table entry layout,
// drain FSM states and the age helper used for ordering against the head.
package retire_queue_pkg;

  localparam int SID_W   = 3;
  localparam int SB_SIZE = 2 ** SID_W;

  typedef logic [SID_W-1:0] sid_t;

  typedef struct packed {
    logic        done;
    logic [4:0]  rd;
    logic [63:0] value;
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Distance from the head in program order; modulo wrap comes from the sid width.
  function automatic sid_t sid_age(input sid_t sid, input sid_t head);
    return sid - head;
  endfunction

endpackage

// File: rtl/retire_queue_table.sv
// Completion table indexed by sid: two capture ports, two read ports (head, head+1),
// per-slot done clear on retire and a bulk done clear on flush. pc/inst kept only
// when RETIRE_TRACE_EN is defined.
module retire_table
  import retire_queue_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   we0_i,
  input  sid_t   wsid0_i,
  input  entry_t wdata0_i,
  input  logic   we1_i,
  input  sid_t   wsid1_i,
  input  entry_t wdata1_i,
  input  logic   clr0_i,
  input  sid_t   csid0_i,
  input  logic   clr1_i,
  input  sid_t   csid1_i,
  input  logic   clr_all_i,
  input  sid_t   rsid0_i,
  input  sid_t   rsid1_i,
  output entry_t rdata0_o,
  output entry_t rdata1_o
);

  logic [SB_SIZE-1:0] done_q, done_d;
  logic [4:0]         rd_q    [SB_SIZE];
  logic [4:0]         rd_d    [SB_SIZE];
  logic [63:0]        value_q [SB_SIZE];
  logic [63:0]        value_d [SB_SIZE];
`ifdef RETIRE_TRACE_EN
  logic [63:0]        pc_q    [SB_SIZE];
  logic [63:0]        pc_d    [SB_SIZE];
  logic [31:0]        inst_q  [SB_SIZE];
  logic [31:0]        inst_d  [SB_SIZE];
`endif
  logic               unused_wr;

  // Clears first, then captures; a flush wipes everything including same-cycle captures.
  always_comb begin
    done_d  = done_q;
    rd_d    = rd_q;
    value_d = value_q;
`ifdef RETIRE_TRACE_EN
    pc_d    = pc_q;
    inst_d  = inst_q;
`endif
    if (clr0_i) done_d[csid0_i] = 1'b0;
    if (clr1_i) done_d[csid1_i] = 1'b0;
    if (we0_i) begin
      done_d[wsid0_i]  = 1'b1;
      rd_d[wsid0_i]    = wdata0_i.rd;
      value_d[wsid0_i] = wdata0_i.value;
`ifdef RETIRE_TRACE_EN
      pc_d[wsid0_i]    = wdata0_i.pc;
      inst_d[wsid0_i]  = wdata0_i.inst;
`endif
    end
    if (we1_i) begin
      done_d[wsid1_i]  = 1'b1;
      rd_d[wsid1_i]    = wdata1_i.rd;
      value_d[wsid1_i] = wdata1_i.value;
`ifdef RETIRE_TRACE_EN
      pc_d[wsid1_i]    = wdata1_i.pc;
      inst_d[wsid1_i]  = wdata1_i.inst;
`endif
    end
    if (clr_all_i) done_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= '0;
    else        done_q <= done_d;
  end

  always_ff @(posedge clk) begin
    rd_q    <= rd_d;
    value_q <= value_d;
`ifdef RETIRE_TRACE_EN
    pc_q    <= pc_d;
    inst_q  <= inst_d;
`endif
  end

  always_comb begin
    rdata0_o       = '0;
    rdata1_o       = '0;
    rdata0_o.done  = done_q[rsid0_i];
    rdata0_o.rd    = rd_q[rsid0_i];
    rdata0_o.value = value_q[rsid0_i];
    rdata1_o.done  = done_q[rsid1_i];
    rdata1_o.rd    = rd_q[rsid1_i];
    rdata1_o.value = value_q[rsid1_i];
`ifdef RETIRE_TRACE_EN
    rdata0_o.pc    = pc_q[rsid0_i];
    rdata0_o.inst  = inst_q[rsid0_i];
    rdata1_o.pc    = pc_q[rsid1_i];
    rdata1_o.inst  = inst_q[rsid1_i];
`endif
  end

`ifdef RETIRE_TRACE_EN
  assign unused_wr = wdata0_i.done ^ wdata1_i.done;
`else
  assign unused_wr = ^{wdata0_i.done, wdata0_i.pc, wdata0_i.inst,
                       wdata1_i.done, wdata1_i.pc, wdata1_i.inst};
`endif

  // Capturing into an entry that is still awaiting retire is a protocol error upstream.
  a_no_overwrite0: assert property (@(posedge clk) disable iff (!rst_n) we0_i |-> !done_q[wsid0_i]);
  a_no_overwrite1: assert property (@(posedge clk) disable iff (!rst_n) we1_i |-> !done_q[wsid1_i]);

endmodule

// File: rtl/retire_queue.sv
// In-order retire of up to two completed instructions per cycle, with redirect
// handled as an ordered drain up to the redirecting sid and a one-cycle flush.
// Optional retire trace outputs under RETIRE_TRACE_EN.
module retire_queue
  import retire_queue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst0_wb_valid_i,
  input  logic [4:0]  inst0_wb_rd_i,
  input  logic [63:0] inst0_wb_value_i,
  input  logic [63:0] inst0_wb_pc_i,
  input  logic [31:0] inst0_wb_inst_i,
  input  sid_t        inst0_wb_sid_i,
  input  logic        inst1_wb_valid_i,
  input  logic [4:0]  inst1_wb_rd_i,
  input  logic [63:0] inst1_wb_value_i,
  input  logic [63:0] inst1_wb_pc_i,
  input  logic [31:0] inst1_wb_inst_i,
  input  sid_t        inst1_wb_sid_i,
  input  logic        wb_redirect_i,
  input  sid_t        wb_redirect_sid_i,
  output logic        rf_we0_o,
  output logic        rf_we1_o,
  output logic [4:0]  rf_waddr0_o,
  output logic [4:0]  rf_waddr1_o,
  output logic [63:0] rf_wdata0_o,
  output logic [63:0] rf_wdata1_o,
  output logic [1:0]  retire_cnt_o,
  output sid_t        head_sid_o,
  output logic        flush_o,
`ifdef RETIRE_TRACE_EN
  output logic        trace0_valid_o,
  output logic [63:0] trace0_pc_o,
  output logic [31:0] trace0_inst_o,
  output logic        trace1_valid_o,
  output logic [63:0] trace1_pc_o,
  output logic [31:0] trace1_inst_o,
`endif
  output state_e      dbg_state_o
);

  state_e      state_q, state_d;
  sid_t        head_q, head_d, flush_sid_q, flush_sid_d;
  sid_t        head_p1, eff_flush;
  logic        filter_en, redir_older, we0, we1;
  logic        slot0, slot1, flush_hit;
  logic [1:0]  retire_cnt;
  entry_t      wdata0, wdata1, rdata0, rdata1;
  logic        rf_we0_q, rf_we0_d, rf_we1_q, rf_we1_d, flush_q, flush_d;
  logic [4:0]  rf_waddr0_q, rf_waddr0_d, rf_waddr1_q, rf_waddr1_d;
  logic [63:0] rf_wdata0_q, rf_wdata0_d, rf_wdata1_q, rf_wdata1_d;
  logic [1:0]  retire_cnt_q, retire_cnt_d;
`ifdef RETIRE_TRACE_EN
  logic        trace0_valid_q, trace0_valid_d, trace1_valid_q, trace1_valid_d;
  logic [63:0] trace0_pc_q, trace0_pc_d, trace1_pc_q, trace1_pc_d;
  logic [31:0] trace0_inst_q, trace0_inst_d, trace1_inst_q, trace1_inst_d;
`else
  logic        unused_trace;
`endif

  assign head_p1 = head_q + sid_t'(1);

  // Effective drain boundary this cycle: a fresh redirect in RUN, or an older one in DRAIN.
  always_comb begin
    redir_older = wb_redirect_i &&
                  (sid_age(wb_redirect_sid_i, head_q) < sid_age(flush_sid_q, head_q));
    eff_flush   = flush_sid_q;
    if ((state_q == RUN) ? wb_redirect_i : redir_older) eff_flush = wb_redirect_sid_i;
    filter_en   = (state_q == DRAIN) || wb_redirect_i;
    we0 = inst0_wb_valid_i &&
          (!filter_en || (sid_age(inst0_wb_sid_i, head_q) <= sid_age(eff_flush, head_q)));
    we1 = inst1_wb_valid_i &&
          (!filter_en || (sid_age(inst1_wb_sid_i, head_q) <= sid_age(eff_flush, head_q)));
  end

  always_comb begin
    wdata0       = '0;
    wdata1       = '0;
    wdata0.done  = 1'b1;
    wdata0.rd    = inst0_wb_rd_i;
    wdata0.value = inst0_wb_value_i;
    wdata1.done  = 1'b1;
    wdata1.rd    = inst1_wb_rd_i;
    wdata1.value = inst1_wb_value_i;
`ifdef RETIRE_TRACE_EN
    wdata0.pc    = inst0_wb_pc_i;
    wdata0.inst  = inst0_wb_inst_i;
    wdata1.pc    = inst1_wb_pc_i;
    wdata1.inst  = inst1_wb_inst_i;
`endif
  end

  retire_table u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .we0_i     (we0),
    .wsid0_i   (inst0_wb_sid_i),
    .wdata0_i  (wdata0),
    .we1_i     (we1),
    .wsid1_i   (inst1_wb_sid_i),
    .wdata1_i  (wdata1),
    .clr0_i    (slot0),
    .csid0_i   (head_q),
    .clr1_i    (slot1),
    .csid1_i   (head_p1),
    .clr_all_i (flush_hit),
    .rsid0_i   (head_q),
    .rsid1_i   (head_p1),
    .rdata0_o  (rdata0),
    .rdata1_o  (rdata1)
  );

  // The redirect cycle itself retires only strictly older entries, so the
  // redirecting instruction always retires from DRAIN together with the flush.
  always_comb begin
    slot0 = rdata0.done;
    slot1 = rdata0.done && rdata1.done;
    if (state_q == RUN && wb_redirect_i) begin
      slot0 = slot0 && (head_q != wb_redirect_sid_i);
      slot1 = slot1 && slot0 && (head_p1 != wb_redirect_sid_i);
    end else if (state_q == DRAIN) begin
      slot1 = slot1 && (head_q != eff_flush);
    end
    flush_hit  = (state_q == DRAIN) &&
                 ((slot0 && head_q == eff_flush) || (slot1 && head_p1 == eff_flush));
    retire_cnt = {1'b0, slot0} + {1'b0, slot1};
  end

  always_comb begin
    state_d     = state_q;
    flush_sid_d = flush_sid_q;
    head_d      = head_q + sid_t'(retire_cnt);
    case (state_q)
      RUN: begin
        if (wb_redirect_i) begin
          state_d     = DRAIN;
          flush_sid_d = wb_redirect_sid_i;
        end
      end
      DRAIN: begin
        flush_sid_d = eff_flush;
        if (flush_hit) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    rf_we0_d     = slot0 && (rdata0.rd != 5'd0);
    rf_we1_d     = slot1 && (rdata1.rd != 5'd0);
    rf_waddr0_d  = slot0 ? rdata0.rd : 5'd0;
    rf_waddr1_d  = slot1 ? rdata1.rd : 5'd0;
    rf_wdata0_d  = slot0 ? rdata0.value : 64'd0;
    rf_wdata1_d  = slot1 ? rdata1.value : 64'd0;
    retire_cnt_d = retire_cnt;
    flush_d      = flush_hit;
`ifdef RETIRE_TRACE_EN
    trace0_valid_d = slot0;
    trace1_valid_d = slot1;
    trace0_pc_d    = slot0 ? rdata0.pc : 64'd0;
    trace1_pc_d    = slot1 ? rdata1.pc : 64'd0;
    trace0_inst_d  = slot0 ? rdata0.inst : 32'd0;
    trace1_inst_d  = slot1 ? rdata1.inst : 32'd0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      head_q       <= '0;
      flush_sid_q  <= '0;
      rf_we0_q     <= 1'b0;
      rf_we1_q     <= 1'b0;
      rf_waddr0_q  <= '0;
      rf_waddr1_q  <= '0;
      rf_wdata0_q  <= '0;
      rf_wdata1_q  <= '0;
      retire_cnt_q <= '0;
      flush_q      <= 1'b0;
`ifdef RETIRE_TRACE_EN
      trace0_valid_q <= 1'b0;
      trace1_valid_q <= 1'b0;
      trace0_pc_q    <= '0;
      trace1_pc_q    <= '0;
      trace0_inst_q  <= '0;
      trace1_inst_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      flush_sid_q  <= flush_sid_d;
      rf_we0_q     <= rf_we0_d;
      rf_we1_q     <= rf_we1_d;
      rf_waddr0_q  <= rf_waddr0_d;
      rf_waddr1_q  <= rf_waddr1_d;
      rf_wdata0_q  <= rf_wdata0_d;
      rf_wdata1_q  <= rf_wdata1_d;
      retire_cnt_q <= retire_cnt_d;
      flush_q      <= flush_d;
`ifdef RETIRE_TRACE_EN
      trace0_valid_q <= trace0_valid_d;
      trace1_valid_q <= trace1_valid_d;
      trace0_pc_q    <= trace0_pc_d;
      trace1_pc_q    <= trace1_pc_d;
      trace0_inst_q  <= trace0_inst_d;
      trace1_inst_q  <= trace1_inst_d;
`endif
    end
  end

  assign rf_we0_o     = rf_we0_q;
  assign rf_we1_o     = rf_we1_q;
  assign rf_waddr0_o  = rf_waddr0_q;
  assign rf_waddr1_o  = rf_waddr1_q;
  assign rf_wdata0_o  = rf_wdata0_q;
  assign rf_wdata1_o  = rf_wdata1_q;
  assign retire_cnt_o = retire_cnt_q;
  assign head_sid_o   = head_q;
  assign flush_o      = flush_q;
  assign dbg_state_o  = state_q;
`ifdef RETIRE_TRACE_EN
  assign trace0_valid_o = trace0_valid_q;
  assign trace1_valid_o = trace1_valid_q;
  assign trace0_pc_o    = trace0_pc_q;
  assign trace1_pc_o    = trace1_pc_q;
  assign trace0_inst_o  = trace0_inst_q;
  assign trace1_inst_o  = trace1_inst_q;
`else
  assign unused_trace = ^{inst0_wb_pc_i, inst0_wb_inst_i, inst1_wb_pc_i, inst1_wb_inst_i,
                          rdata0.pc, rdata0.inst, rdata1.pc, rdata1.inst};
`endif

endmodule

// File: tb/tb_retire_queue.sv
// Directed bench for retire_queue: ordered dual retire, x0 destinations, head wrap,
// redirect drain/flush, redirect replacement and reset during drain.
module tb_retire_queue;
  import retire_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst0_wb_valid_i, inst1_wb_valid_i;
  logic [4:0]  inst0_wb_rd_i, inst1_wb_rd_i;
  logic [63:0] inst0_wb_value_i, inst1_wb_value_i;
  logic [63:0] inst0_wb_pc_i, inst1_wb_pc_i;
  logic [31:0] inst0_wb_inst_i, inst1_wb_inst_i;
  sid_t        inst0_wb_sid_i, inst1_wb_sid_i;
  logic        wb_redirect_i;
  sid_t        wb_redirect_sid_i;
  logic        rf_we0_o, rf_we1_o, flush_o;
  logic [4:0]  rf_waddr0_o, rf_waddr1_o;
  logic [63:0] rf_wdata0_o, rf_wdata1_o;
  logic [1:0]  retire_cnt_o;
  sid_t        head_sid_o;
  state_e      dbg_state_o;
`ifdef RETIRE_TRACE_EN
  logic        trace0_valid_o, trace1_valid_o;
  logic [63:0] trace0_pc_o, trace1_pc_o;
  logic [31:0] trace0_inst_o, trace1_inst_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  retire_queue dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .inst0_wb_valid_i  (inst0_wb_valid_i),
    .inst0_wb_rd_i     (inst0_wb_rd_i),
    .inst0_wb_value_i  (inst0_wb_value_i),
    .inst0_wb_pc_i     (inst0_wb_pc_i),
    .inst0_wb_inst_i   (inst0_wb_inst_i),
    .inst0_wb_sid_i    (inst0_wb_sid_i),
    .inst1_wb_valid_i  (inst1_wb_valid_i),
    .inst1_wb_rd_i     (inst1_wb_rd_i),
    .inst1_wb_value_i  (inst1_wb_value_i),
    .inst1_wb_pc_i     (inst1_wb_pc_i),
    .inst1_wb_inst_i   (inst1_wb_inst_i),
    .inst1_wb_sid_i    (inst1_wb_sid_i),
    .wb_redirect_i     (wb_redirect_i),
    .wb_redirect_sid_i (wb_redirect_sid_i),
    .rf_we0_o          (rf_we0_o),
    .rf_we1_o          (rf_we1_o),
    .rf_waddr0_o       (rf_waddr0_o),
    .rf_waddr1_o       (rf_waddr1_o),
    .rf_wdata0_o       (rf_wdata0_o),
    .rf_wdata1_o       (rf_wdata1_o),
    .retire_cnt_o      (retire_cnt_o),
    .head_sid_o        (head_sid_o),
    .flush_o           (flush_o),
`ifdef RETIRE_TRACE_EN
    .trace0_valid_o    (trace0_valid_o),
    .trace0_pc_o       (trace0_pc_o),
    .trace0_inst_o     (trace0_inst_o),
    .trace1_valid_o    (trace1_valid_o),
    .trace1_pc_o       (trace1_pc_o),
    .trace1_inst_o     (trace1_inst_o),
`endif
    .dbg_state_o       (dbg_state_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ret(input string tag, input logic [63:0] cnt,
                           input logic [63:0] we0, input logic [63:0] a0, input logic [63:0] d0,
                           input logic [63:0] we1, input logic [63:0] a1, input logic [63:0] d1,
                           input logic [63:0] fl, input logic [63:0] hd);
    chk({tag, ".cnt"},   retire_cnt_o, cnt);
    chk({tag, ".we0"},   rf_we0_o, we0);
    chk({tag, ".addr0"}, rf_waddr0_o, a0);
    chk({tag, ".data0"}, rf_wdata0_o, d0);
    chk({tag, ".we1"},   rf_we1_o, we1);
    chk({tag, ".addr1"}, rf_waddr1_o, a1);
    chk({tag, ".data1"}, rf_wdata1_o, d1);
    chk({tag, ".flush"}, flush_o, fl);
    chk({tag, ".head"},  head_sid_o, hd);
`ifdef RETIRE_TRACE_EN
    chk({tag, ".tv0"},   trace0_valid_o, 64'(cnt >= 1));
    chk({tag, ".tv1"},   trace1_valid_o, 64'(cnt == 2));
`endif
  endtask

  task automatic check_idle(input string tag, input logic [63:0] hd);
    check_ret(tag, 0, 0, 0, 0, 0, 0, 0, 0, hd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst0_wb_valid_i  = 1'b0;
    inst0_wb_rd_i     = '0;
    inst0_wb_value_i  = '0;
    inst0_wb_pc_i     = '0;
    inst0_wb_inst_i   = '0;
    inst0_wb_sid_i    = '0;
    inst1_wb_valid_i  = 1'b0;
    inst1_wb_rd_i     = '0;
    inst1_wb_value_i  = '0;
    inst1_wb_pc_i     = '0;
    inst1_wb_inst_i   = '0;
    inst1_wb_sid_i    = '0;
    wb_redirect_i     = 1'b0;
    wb_redirect_sid_i = '0;
  endtask

  task automatic set_wb0(input sid_t sid, input logic [4:0] rd, input logic [63:0] val);
    inst0_wb_valid_i = 1'b1;
    inst0_wb_sid_i   = sid;
    inst0_wb_rd_i    = rd;
    inst0_wb_value_i = val;
    inst0_wb_pc_i    = 64'h1000 + val;
    inst0_wb_inst_i  = 32'h13 + 32'(sid);
  endtask

  task automatic set_wb1(input sid_t sid, input logic [4:0] rd, input logic [63:0] val);
    inst1_wb_valid_i = 1'b1;
    inst1_wb_sid_i   = sid;
    inst1_wb_rd_i    = rd;
    inst1_wb_value_i = val;
    inst1_wb_pc_i    = 64'h2000 + val;
    inst1_wb_inst_i  = 32'h33 + 32'(sid);
  endtask

  task automatic set_redir(input sid_t sid);
    wb_redirect_i     = 1'b1;
    wb_redirect_sid_i = sid;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset", 0);
    chk("reset.state", dbg_state_o, RUN);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("idle", 0);
    end

    // Dual capture, dual retire two cycles later.
    set_wb0(0, 5, 64'h11);
    set_wb1(1, 6, 64'h22);
    step();
    idle();
    step();
    check_ret("dual", 2, 1, 5, 64'h11, 1, 6, 64'h22, 0, 2);
    step();
    check_idle("dual_after", 2);

    // Out of order completion: younger sid3 first, head sid2 three cycles later.
    set_wb0(3, 7, 64'h33);
    step();
    idle();
    check_idle("ooo_c1", 2);
    step();
    check_idle("ooo_c2", 2);
    step();
    check_idle("ooo_c3", 2);
    set_wb0(2, 8, 64'h44);
    step();
    idle();
    check_idle("ooo_c4", 2);
    step();
    check_ret("ooo_c5", 2, 1, 8, 64'h44, 1, 7, 64'h33, 0, 4);

    // x0 destination retires and counts without a write enable.
    set_wb0(4, 0, 64'h55);
    step();
    idle();
    step();
    check_ret("x0", 1, 0, 0, 64'h55, 0, 0, 0, 0, 5);

    set_wb0(5, 9, 64'h66);
    step();
    idle();
    step();
    check_ret("to_head6", 1, 1, 9, 64'h66, 0, 0, 0, 0, 6);

    // Head wrap 6,7 then 0,1.
    set_wb0(6, 10, 64'hA6);
    set_wb1(7, 11, 64'hA7);
    step();
    set_wb0(0, 12, 64'hB0);
    set_wb1(1, 13, 64'hB1);
    step();
    idle();
    check_ret("wrap_a", 2, 1, 10, 64'hA6, 1, 11, 64'hA7, 0, 0);
    step();
    check_ret("wrap_b", 2, 1, 12, 64'hB0, 1, 13, 64'hB1, 0, 2);
    step();
    check_idle("wrap_after", 2);

    // Redirect sid4 at head 2: retire 2,3,4 only, drop 5 and 6, flush with 4.
    set_wb0(2, 1, 64'hC2);
    set_wb1(3, 2, 64'hC3);
    set_redir(4);
    step();
    idle();
    set_wb0(4, 3, 64'hC4);
    set_wb1(5, 4, 64'hC5);
    check_idle("drain_c1", 2);
    chk("drain_c1.state", dbg_state_o, DRAIN);
    step();
    idle();
    set_wb0(6, 5, 64'hC6);
    check_ret("drain_c2", 2, 1, 1, 64'hC2, 1, 2, 64'hC3, 0, 4);
    chk("drain_c2.state", dbg_state_o, DRAIN);
    step();
    idle();
    check_ret("drain_flush", 1, 1, 3, 64'hC4, 0, 0, 0, 1, 5);
    chk("drain_flush.state", dbg_state_o, RUN);
    set_wb0(5, 6, 64'hD5);
    step();
    idle();
    check_idle("drain_post", 5);
    step();
    check_ret("drain_resume", 1, 1, 6, 64'hD5, 0, 0, 0, 0, 6);

    // Redirect at a done head: one drain cycle, younger done entry discarded.
    set_wb0(6, 7, 64'hE6);
    set_wb1(7, 8, 64'hE7);
    step();
    idle();
    set_redir(6);
    check_idle("headredir_c1", 6);
    step();
    idle();
    check_idle("headredir_c2", 6);
    chk("headredir_c2.state", dbg_state_o, DRAIN);
    step();
    check_ret("headredir_flush", 1, 1, 7, 64'hE6, 0, 0, 0, 1, 7);
    chk("headredir_flush.state", dbg_state_o, RUN);
    step();
    check_idle("headredir_cleared", 7);

    // Older redirect replaces the boundary, a younger one is ignored.
    set_redir(2);
    step();
    set_redir(0);
    set_wb0(0, 10, 64'hF0);
    set_wb1(1, 11, 64'hF1);
    check_idle("replace_c1", 7);
    step();
    idle();
    set_redir(4);
    set_wb0(7, 12, 64'hF7);
    check_idle("replace_c2", 7);
    chk("replace_c2.state", dbg_state_o, DRAIN);
    step();
    idle();
    check_idle("replace_c3", 7);
    step();
    check_ret("replace_flush", 2, 1, 12, 64'hF7, 1, 10, 64'hF0, 1, 1);
    chk("replace_flush.state", dbg_state_o, RUN);
    step();
    check_idle("replace_after", 1);

    // Redirect in the same cycle as its own writeback.
    set_wb0(1, 13, 64'h71);
    set_redir(1);
    step();
    idle();
    check_idle("self_c1", 1);
    chk("self_c1.state", dbg_state_o, DRAIN);
    step();
    check_ret("self_flush", 1, 1, 13, 64'h71, 0, 0, 0, 1, 2);

    // Reset in the middle of a drain.
    set_wb0(0, 14, 64'h80);
    step();
    idle();
    set_redir(5);
    step();
    idle();
    chk("rst_mid.state_before", dbg_state_o, DRAIN);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid", 0);
    chk("rst_mid.state", dbg_state_o, RUN);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("rst_after", 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
